// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM period / high-time capture block.
package pwm_capture_pkg;

   localparam int RES_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARM,
      ST_HIGH,
      ST_LOW
   } state_t;

   typedef struct packed {
      logic [RES_W-1:0] period;
      logic [RES_W-1:0] high_time;
      logic             overflow;
      logic             stuck_level;
   } res_t;

   // All-ones value of a cnt_bits-wide counter, zero-extended to RES_W.
   function automatic logic [RES_W-1:0] sat_count(input int cnt_bits);
      return (RES_W'(1) << cnt_bits) - RES_W'(1);
   endfunction

endpackage

// File: rtl/pwm_capture_sync.sv
// PWM input synchronizer with edge detect; optional glitch filter when
// PWM_CAPTURE_GLITCH_FILTER_EN is defined.
module pwm_capture_sync #(
   parameter int SYNC_STAGES = 2
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   , parameter int FILT_LEN  = 3
`endif
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_pwm_in,
   output logic o_s,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_s_d;
   logic                   w_s;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_sync <= '0;
      else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_pwm_in};
   end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   localparam int RUN_W = $clog2(FILT_LEN + 1);

   logic [RUN_W-1:0] r_run;
   logic             r_filt;

   // r_run counts consecutive samples disagreeing with the filtered level.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_run  <= '0;
         r_filt <= 1'b0;
      end else if (r_sync[SYNC_STAGES-1] == r_filt) begin
         r_run <= '0;
      end else if (r_run == RUN_W'(FILT_LEN - 1)) begin
         r_filt <= r_sync[SYNC_STAGES-1];
         r_run  <= '0;
      end else begin
         r_run <= r_run + 1'b1;
      end
   end

   assign w_s = r_filt;
`else
   assign w_s = r_sync[SYNC_STAGES-1];
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_s_d <= 1'b0;
      else       r_s_d <= w_s;
   end

   assign o_s    = w_s;
   assign o_rise = w_s & ~r_s_d;
   assign o_fall = ~w_s & r_s_d;

endmodule

// File: rtl/pwm_capture.sv
// Measures PWM period and high time in clock cycles, reporting via valid/ready.
// Build with PWM_CAPTURE_GLITCH_FILTER_EN to add the input glitch filter.
module pwm_capture
   import pwm_capture_pkg::*;
#(
   parameter int CNT_BITS    = 16,
   parameter int SYNC_STAGES = 2
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   , parameter int FILT_LEN  = 3
`endif
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_pwm_in,
   input  logic                i_enable,
   input  logic                i_meas_ready,
   output logic                o_meas_valid,
   output logic [CNT_BITS-1:0] o_period,
   output logic [CNT_BITS-1:0] o_high_time,
   output logic                o_overflow,
   output logic                o_stuck_level,
   output logic                o_overrun
);

   localparam logic [CNT_BITS-1:0] SAT = CNT_BITS'(sat_count(CNT_BITS));

   logic                w_s;
   logic                w_rise;
   logic                w_fall;
   state_t              r_state;
   logic [CNT_BITS-1:0] r_cnt;
   logic [CNT_BITS-1:0] r_hi_cap;
   res_t                w_res;
   logic                w_res_vld;
   logic                w_sat;
   res_t                r_res;
   logic                r_valid;
   logic                r_overrun;
   logic                w_unused;

   pwm_capture_sync #(
      .SYNC_STAGES (SYNC_STAGES)
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
      , .FILT_LEN  (FILT_LEN)
`endif
   ) u_sync (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_pwm_in (i_pwm_in),
      .o_s      (w_s),
      .o_rise   (w_rise),
      .o_fall   (w_fall)
   );

   // Saturation outranks a coincident edge so a stuck input is always reported.
   assign w_sat = (r_state == ST_HIGH || r_state == ST_LOW) && (r_cnt == SAT);

   always_comb begin
      w_res_vld = 1'b0;
      w_res     = '0;
      if (i_enable) begin
         if (w_sat) begin
            w_res_vld         = 1'b1;
            w_res.period      = RES_W'(SAT);
            w_res.high_time   = (r_state == ST_HIGH) ? RES_W'(SAT) : RES_W'(r_hi_cap);
            w_res.overflow    = 1'b1;
            w_res.stuck_level = w_s;
         end else if (r_state == ST_LOW && w_rise) begin
            w_res_vld       = 1'b1;
            w_res.period    = RES_W'(r_cnt);
            w_res.high_time = RES_W'(r_hi_cap);
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_hi_cap <= '0;
      end else if (!i_enable) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: r_state <= ST_ARM;
            ST_ARM: begin
               if (w_rise) begin
                  r_state <= ST_HIGH;
                  r_cnt   <= CNT_BITS'(1);
               end
            end
            ST_HIGH: begin
               if (w_sat) begin
                  r_state <= ST_ARM;
                  r_cnt   <= '0;
               end else if (w_fall) begin
                  r_state  <= ST_LOW;
                  r_hi_cap <= r_cnt;
                  r_cnt    <= r_cnt + 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_LOW: begin
               if (w_sat) begin
                  r_state <= ST_ARM;
                  r_cnt   <= '0;
               end else if (w_rise) begin
                  r_state <= ST_HIGH;
                  r_cnt   <= CNT_BITS'(1);
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // A result arriving while the previous one is still held is dropped.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_res     <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_overrun <= 1'b0;
         if (!i_enable) begin
            r_valid <= 1'b0;
         end else if (w_res_vld) begin
            if (!r_valid || i_meas_ready) begin
               r_res   <= w_res;
               r_valid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (r_valid && i_meas_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign o_meas_valid  = r_valid;
   assign o_period      = r_res.period[CNT_BITS-1:0];
   assign o_high_time   = r_res.high_time[CNT_BITS-1:0];
   assign o_overflow    = r_res.overflow;
   assign o_stuck_level = r_res.stuck_level;
   assign o_overrun     = r_overrun;
   assign w_unused      = ^{r_res.period, r_res.high_time};

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: table vectors, directed corner cases,
// and randomized waveforms against a timestamp-based reference model.
module tb_pwm_capture;

   localparam int CB   = 8;
   localparam int SS   = 2;
   localparam int FL   = 3;
   localparam int MAXV = 255;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          pwm = 1'b0;
   logic          en  = 1'b0;
   logic          rdy = 1'b0;
   logic          o_meas_valid;
   logic [CB-1:0] o_period;
   logic [CB-1:0] o_high_time;
   logic          o_overflow;
   logic          o_stuck_level;
   logic          o_overrun;

   pwm_capture #(
      .CNT_BITS    (CB),
      .SYNC_STAGES (SS)
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
      , .FILT_LEN  (FL)
`endif
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_pwm_in      (pwm),
      .i_enable      (en),
      .i_meas_ready  (rdy),
      .o_meas_valid  (o_meas_valid),
      .o_period      (o_period),
      .o_high_time   (o_high_time),
      .o_overflow    (o_overflow),
      .o_stuck_level (o_stuck_level),
      .o_overrun     (o_overrun)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc_n = 0;
   int n_ovr = 0;
   bit chk_on = 1'b0;

   typedef struct {
      int per;
      int hi;
      bit ovf;
      bit stk;
      int cyc;
   } rec_t;
   rec_t got_q[$];

   // ---------------- reference model (timestamps of edges of s) ----------------
   bit ph [0:SS];
   bit win [0:FL-1];
   bit m_fs = 1'b0;
   bit m_s_prev = 1'b0;
   int t = 0;
   int phase = 0;          // 0 disabled, 1 waiting for first rise, 2 measuring
   int t_rise = 0;
   int t_fall = 0;
   bit seen_fall = 1'b0;
   bit m_valid = 1'b0;
   bit m_overrun = 1'b0;
   int m_per = 0;
   int m_hi = 0;
   bit m_ovf = 1'b0;
   bit m_stk = 1'b0;
   bit s_cur, sd_cur, rise, fall, got, r_ovf, r_stk, all_eq, ok;
   int r_per, r_hi;

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         for (int i = 0; i <= SS; i++) ph[i] = 1'b0;
         for (int i = 0; i < FL; i++) win[i] = 1'b0;
         m_fs = 0; m_s_prev = 0; phase = 0; seen_fall = 0;
         m_valid = 0; m_overrun = 0; m_per = 0; m_hi = 0; m_ovf = 0; m_stk = 0;
      end else begin
         t++;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
         s_cur = m_fs;
`else
         s_cur = ph[SS-1];
`endif
         sd_cur = m_s_prev;
         rise = s_cur && !sd_cur;
         fall = !s_cur && sd_cur;
         got = 0; r_per = 0; r_hi = 0; r_ovf = 0; r_stk = 0;
         if (!en) phase = 0;
         else if (phase == 0) phase = 1;
         else if (phase == 1) begin
            if (rise) begin phase = 2; t_rise = t; seen_fall = 0; end
         end else begin
            if (t - t_rise == MAXV) begin
               got = 1; r_per = MAXV; r_ovf = 1; r_stk = s_cur;
               r_hi = seen_fall ? t_fall - t_rise : MAXV;
               phase = 1;
            end else if (rise) begin
               got = 1; r_per = t - t_rise; r_hi = t_fall - t_rise;
               t_rise = t; seen_fall = 0;
            end else if (fall) begin
               t_fall = t; seen_fall = 1;
            end
         end
         m_overrun = 0;
         if (!en) m_valid = 0;
         else if (got) begin
            if (!m_valid || rdy) begin
               m_valid = 1; m_per = r_per; m_hi = r_hi; m_ovf = r_ovf; m_stk = r_stk;
            end else m_overrun = 1;
         end else if (m_valid && rdy) m_valid = 0;
         m_s_prev = s_cur;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
         for (int i = FL - 1; i > 0; i--) win[i] = win[i-1];
         win[0] = ph[SS-1];
         all_eq = 1;
         for (int i = 1; i < FL; i++) if (win[i] != win[0]) all_eq = 0;
         if (all_eq && win[0] != m_fs) m_fs = win[0];
`endif
         for (int i = SS; i > 0; i--) ph[i] = ph[i-1];
         ph[0] = pwm;
      end
   end

   initial forever begin
      @(posedge clk);
      cyc_n++;
   end

   // ---------------- per-cycle comparison and result monitor ----------------
   initial forever begin
      @(negedge clk);
      if (chk_on) begin
         n_cmp++;
         ok = (o_meas_valid === m_valid) && (o_overrun === m_overrun);
         if (m_valid)
            ok = ok && (o_period === CB'(m_per)) && (o_high_time === CB'(m_hi)) &&
                 (o_overflow === m_ovf) && (o_stuck_level === m_stk);
         if (!ok) begin
            n_bad++;
            $display("FAIL model_cycle cyc=%0d: got v=%0b ovr=%0b per=%0d hi=%0d ovf=%0b stk=%0b, want v=%0b ovr=%0b per=%0d hi=%0d ovf=%0b stk=%0b",
                     cyc_n, o_meas_valid, o_overrun, o_period, o_high_time, o_overflow, o_stuck_level,
                     m_valid, m_overrun, m_per, m_hi, m_ovf, m_stk);
         end
      end
      if (o_meas_valid && rdy)
         got_q.push_back('{int'(o_period), int'(o_high_time), o_overflow, o_stuck_level, cyc_n});
      if (o_overrun) n_ovr++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input logic lvl, input int n);
      pwm = lvl;
      tick(n);
   endtask

   task automatic rearm(input logic r);
      en = 0; pwm = 0; rdy = r;
      tick(8);
      en = 1;
      tick(2);
      got_q.delete();
   endtask

   typedef struct {
      int hi;
      int per;
      int nper;
      int exp_per;
      int exp_hi;
   } vec_t;
   vec_t vt [5];
   int   o0;
   int   rsel;

   initial begin
      vt[0] = '{5, 10, 6, 10, 5};
      vt[1] = '{1, 8, 5, 8, 1};
      vt[2] = '{7, 8, 5, 8, 7};
      vt[3] = '{13, 20, 4, 20, 13};
      vt[4] = '{1, 2, 6, 2, 1};

      // Reset state
      tick(3);
      chk("rst_valid", o_meas_valid, 0);
      chk("rst_period", o_period, 0);
      chk("rst_high", o_high_time, 0);
      chk("rst_ovf", o_overflow, 0);
      chk("rst_stuck", o_stuck_level, 0);
      chk("rst_overrun", o_overrun, 0);
      rst = 0;
      chk_on = 1;

      // Steady waveforms from the vector table
      for (int v = 0; v < 5; v++) begin
         rearm(1);
         repeat (vt[v].nper) begin
            drive(1, vt[v].hi);
            drive(0, vt[v].per - vt[v].hi);
         end
         tick(6);
         chk("tbl_count", got_q.size(), vt[v].nper - 1);
         foreach (got_q[i]) begin
            chk("tbl_period", got_q[i].per, vt[v].exp_per);
            chk("tbl_high", got_q[i].hi, vt[v].exp_hi);
            chk("tbl_ovf", got_q[i].ovf, 0);
            if (i > 0) chk("tbl_spacing", got_q[i].cyc - got_q[i-1].cyc, vt[v].per);
         end
      end

      // Stuck high: saturate, then back to ARM
      rearm(1);
      drive(1, 300);
      chk("sat_hi_count", got_q.size(), 1);
      if (got_q.size() >= 1) begin
         chk("sat_hi_period", got_q[0].per, MAXV);
         chk("sat_hi_high", got_q[0].hi, MAXV);
         chk("sat_hi_ovf", got_q[0].ovf, 1);
         chk("sat_hi_stuck", got_q[0].stk, 1);
      end
      drive(1, 100);
      chk("sat_hi_quiet", got_q.size(), 1);
      drive(0, 3); drive(1, 4); drive(0, 6); drive(1, 4); drive(0, 6);
      chk("sat_rearm_count", got_q.size(), 2);
      if (got_q.size() >= 2) begin
         chk("sat_rearm_period", got_q[1].per, 10);
         chk("sat_rearm_high", got_q[1].hi, 4);
      end

      // Stuck low after a 3-cycle high pulse
      rearm(1);
      drive(1, 3);
      drive(0, 300);
      chk("sat_lo_count", got_q.size(), 1);
      if (got_q.size() >= 1) begin
         chk("sat_lo_period", got_q[0].per, MAXV);
         chk("sat_lo_high", got_q[0].hi, 3);
         chk("sat_lo_ovf", got_q[0].ovf, 1);
         chk("sat_lo_stuck", got_q[0].stk, 0);
      end

      // Back-pressure: first result held, two dropped
      rearm(0);
      o0 = n_ovr;
      repeat (4) begin drive(1, 5); drive(0, 5); end
      tick(4);
      chk("hold_valid", o_meas_valid, 1);
      chk("hold_period", o_period, 10);
      chk("hold_high", o_high_time, 5);
      chk("hold_overruns", n_ovr - o0, 2);
      rdy = 1;
      tick(1);
      chk("hold_release", o_meas_valid, 0);

      // Enable drop clears a held result
      rdy = 0;
      drive(1, 5); drive(0, 5); drive(1, 5); drive(0, 5);
      chk("en_valid_before", o_meas_valid, 1);
      en = 0;
      tick(1);
      chk("en_valid_after", o_meas_valid, 0);

      // Asynchronous reset mid-HIGH
      rearm(0);
      drive(1, 5); drive(0, 5); drive(1, 5); drive(0, 5);
      drive(1, 3);
      #3 rst = 1;
      #1;
      chk("arst_valid", o_meas_valid, 0);
      chk("arst_period", o_period, 0);
      chk("arst_high", o_high_time, 0);
      chk("arst_ovf", o_overflow, 0);
      chk("arst_stuck", o_stuck_level, 0);
      chk("arst_overrun", o_overrun, 0);
      @(posedge clk);
      #1 rst = 0;
      rdy = 1;
      got_q.delete();
      drive(1, 2); drive(0, 5);
      chk("arst_one_rise", got_q.size(), 0);
      drive(1, 5); drive(0, 5);
      chk("arst_two_rises", got_q.size(), 1);

      // Two-cycle glitch inside the low phase
      rearm(1);
      drive(1, 5); drive(0, 5); drive(1, 2); drive(0, 8);
      drive(1, 5); drive(0, 15);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
      chk("glitch_count", got_q.size(), 1);
      if (got_q.size() >= 1) begin
         chk("glitch_period", got_q[0].per, 20);
         chk("glitch_high", got_q[0].hi, 5);
      end
`else
      chk("glitch_count", got_q.size(), 2);
      if (got_q.size() >= 2) begin
         chk("glitch_per0", got_q[0].per, 10);
         chk("glitch_hi0", got_q[0].hi, 5);
         chk("glitch_per1", got_q[1].per, 10);
         chk("glitch_hi1", got_q[1].hi, 2);
      end
`endif

      // Randomized waveforms, back-pressure and enable drops
      rearm(1);
      for (int k = 0; k < 400; k++) begin
         rsel = $urandom_range(0, 99);
         rdy = ($urandom_range(0, 3) != 0);
         if (rsel < 3) begin
            en = 0;
            tick($urandom_range(1, 3));
            en = 1;
         end else if (rsel < 7) begin
            drive(!pwm, $urandom_range(200, 300));
         end else begin
            drive(!pwm, $urandom_range(1, 25));
         end
      end
      tick(10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures period and high time of a PWM waveform, in clock cycles. It sits directly downstream of the PWM generator and lets firmware or a closed-loop controller confirm the generated duty cycle. Results go out through a valid/ready handshake. Saturation reports a stuck-high or stuck-low input.

## Interface
- CNT_BITS, 16, width of the cycle counters and result fields
- SYNC_STAGES, 2, synchronizer flops on PWM_IN (minimum 2)
- FILT_LEN, 3, consecutive equal samples required by the glitch filter (used only with the macro)

- CLK  in  1  sole clock
- RST  in  1  asynchronous, active-high reset
- PWM_IN  in  1  waveform under measurement (asynchronous to CLK)
- ENABLE  in  1  measurement enable, level-sensitive
- MEAS_READY  in  1  consumer accepts the result
- MEAS_VALID  out  1  result available
- PERIOD  out  CNT_BITS  rise-to-rise cycles
- HIGH_TIME  out  CNT_BITS  rise-to-fall cycles
- OVERFLOW  out  1  result produced by saturation, not by an edge
- STUCK_LEVEL  out  1  synchronized level at saturation
- OVERRUN  out  1  one-cycle pulse: a result was discarded

## Operation
- s is PWM_IN after synchronization (and filtering when enabled); s_d is s delayed one cycle.
- Edge detects: rise = s & ~s_d, fall = ~s & s_d.
- States:
  - IDLE: entered from any state when ENABLE=0. Counter cleared.
  - ARM: entered when ENABLE=1. Waits for rise.
  - HIGH: entered on rise.
  - LOW: entered on fall.
- ARM -> HIGH on rise; cnt <= 1.
- HIGH -> LOW on fall; hi_cap <= cnt; cnt increments.
- LOW -> HIGH on rise:
  - Result: PERIOD = cnt, HIGH_TIME = hi_cap, OVERFLOW = 0.
  - cnt <= 1, so measurement is continuous.
- cnt increments every cycle in HIGH/LOW, except on the rise cycle.
- Saturation: cnt reaching 2^CNT_BITS-1 in HIGH or LOW produces a result, then the FSM returns to ARM.
  - PERIOD = all-ones.
  - HIGH_TIME = all-ones if in HIGH, hi_cap if in LOW.
  - OVERFLOW = 1, STUCK_LEVEL = s.
- Output register:
  - Loaded when a result is produced and (MEAS_VALID=0 or MEAS_READY=1).
  - Held stable while MEAS_VALID=1 and MEAS_READY=0.
  - A result produced while held is dropped, and OVERRUN pulses.
- MEAS_VALID clears on handshake (VALID & READY) with no new result that cycle.
- A handshake and a new result in the same cycle load the new result, and VALID stays 1.
- ENABLE deassertion clears MEAS_VALID and goes to IDLE in the next cycle.

## Timing
- Reset values: MEAS_VALID=0, PERIOD=0, HIGH_TIME=0, OVERFLOW=0, STUCK_LEVEL=0, OVERRUN=0; FSM=IDLE; cnt=0; sync flops=0.
- PWM_IN edge to rise/fall detection: SYNC_STAGES+1 cycles (plus FILT_LEN with filter).
- Detection to MEAS_VALID high: 1 cycle (registered).
- Reset mid-measurement aborts with no result. After release, the first result needs two rising edges.
- Minimum resolvable pulse: 1 cycle of s. Shorter PWM_IN pulses may be missed, by design.

## Configuration
- PWM_CAPTURE_GLITCH_FILTER_EN defined:
  - s changes only after FILT_LEN consecutive identical synchronized samples.
  - Pulses shorter than FILT_LEN cycles are ignored.
  - Detection latency grows by FILT_LEN.
- Undefined: s = synchronizer output, with no filter logic or FILT_LEN usage.

## Structure
- Package pwm_capture_pkg holds:
  - FSM state enum (IDLE, ARM, HIGH, LOW).
  - Result struct (period, high_time, overflow, stuck_level).
  - Saturation constant derived from CNT_BITS.
- Sub-module pwm_capture_sync: synchronizer, optional glitch filter, s_d register, rise/fall outputs.

## Test plan
- Steady input, period 10, high 5, MEAS_READY=1 -> every result PERIOD=10, HIGH_TIME=5, OVERFLOW=0, one per 10 cycles.
- Period 8, high 1, then period 8, high 7 -> HIGH_TIME=1 and 7, both with PERIOD=8.
- PWM_IN held high with CNT_BITS=8 -> PERIOD=255, HIGH_TIME=255, OVERFLOW=1, STUCK_LEVEL=1; FSM returns to ARM.
- MEAS_READY=0 across three periods -> first result held unchanged, OVERRUN pulses twice; READY=1 releases it.
- RST asserted mid-HIGH, then released -> all outputs 0 immediately; first valid result only after two rises.
- With the filter macro and FILT_LEN=3, a 2-cycle glitch inside the low phase -> ignored, PERIOD unchanged. Without the macro, the same glitch produces a short result.
